// File: rtl/jump_ctrl_pkg.sv
// Shared types and constants for the jump/branch issue controller.
package jump_ctrl_pkg;
    localparam int XLEN       = 32;
    localparam int REG_IDX_W  = 5;
    localparam int CMP_W      = 4;
    localparam int CMP_UNCOND = 0;
    localparam int WDOG_W     = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RESOLVE = 2'd3
    } state_e;

    typedef struct packed {
        logic                 jalr;
        logic [CMP_W-1:0]     cmp_ctrl;
        logic [XLEN-1:0]      rs1;
        logic [XLEN-1:0]      rs2;
        logic [XLEN-1:0]      imm;
        logic [XLEN-1:0]      pc;
        logic [REG_IDX_W-1:0] rd;
        logic                 wb;
    } jump_req_t;

    typedef struct packed {
        logic            is_jump;
        logic [XLEN-1:0] pc_jump;
        logic [XLEN-1:0] pc_wb;
    } jump_rsp_t;
endpackage

// File: rtl/jump_watchdog.sv
// Clear/enable/limit cycle counter for multi-cycle FU controllers.
module jump_watchdog #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] limit_i,
    output logic         hit_o
);
    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i)
            count_d = '0;
        else if (en_i)
            count_d = count_q + W'(1);
    end

    // hit flags the enabled cycle whose increment reaches the limit
    assign hit_o = en_i && ((count_q + W'(1)) == limit_i);

    always_ff @(posedge clk) begin
        if (!rst_n)
            count_q <= '0;
        else
            count_q <= count_d;
    end
endmodule

// File: rtl/jump_issue_ctrl.sv
// Issue-side controller for the jump FU: buffer, one-shot enable, wait with
// watchdog, then redirect and rd writeback.
module jump_issue_ctrl
    import jump_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 issue_valid,
    output logic                 issue_ready,
    input  logic                 issue_jalr,
    input  logic [CMP_W-1:0]     issue_cmp_ctrl,
    input  logic [XLEN-1:0]      issue_rs1,
    input  logic [XLEN-1:0]      issue_rs2,
    input  logic [XLEN-1:0]      issue_imm,
    input  logic [XLEN-1:0]      issue_pc,
    input  logic [REG_IDX_W-1:0] issue_rd,
    input  logic                 issue_wb,
    output logic                 fu_en,
    output logic                 fu_jalr,
    output logic [CMP_W-1:0]     fu_cmp_ctrl,
    output logic [XLEN-1:0]      fu_rs1,
    output logic [XLEN-1:0]      fu_rs2,
    output logic [XLEN-1:0]      fu_imm,
    output logic [XLEN-1:0]      fu_pc,
    input  logic                 fu_finish,
    input  logic                 fu_is_jump,
    input  logic [XLEN-1:0]      fu_pc_jump,
    input  logic [XLEN-1:0]      fu_pc_wb,
    output logic                 redirect_valid,
    output logic [XLEN-1:0]      redirect_pc,
    output logic                 wb_req,
    input  logic                 wb_ack,
    output logic [REG_IDX_W-1:0] wb_rd,
    output logic [XLEN-1:0]      wb_data,
    output logic                 fetch_stall,
    output logic                 timeout_err
);
    localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(TIMEOUT);

    state_e    state_q, state_d;
    jump_req_t req_q, req_d;
    jump_rsp_t rsp_q, rsp_d;
    logic      first_q, first_d;
    logic      err_q, err_d;
    logic      wdog_clr, wdog_en, wdog_hit;

    assign wdog_clr = (state_q == ST_ISSUE);
    assign wdog_en  = (state_q == ST_WAIT) && !fu_finish;

    jump_watchdog #(.W(WDOG_W)) u_wdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (wdog_clr),
        .en_i    (wdog_en),
        .limit_i (WDOG_LIMIT),
        .hit_o   (wdog_hit)
    );

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        rsp_d   = rsp_q;
        first_d = first_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (issue_valid) begin
                    req_d.jalr     = issue_jalr;
                    req_d.cmp_ctrl = issue_cmp_ctrl;
                    req_d.rs1      = issue_rs1;
                    req_d.rs2      = issue_rs2;
                    req_d.imm      = issue_imm;
                    req_d.pc       = issue_pc;
                    req_d.rd       = issue_rd;
                    req_d.wb       = issue_wb;
                    state_d        = ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                // a finish on the limit cycle takes priority over the timeout
                if (fu_finish) begin
                    rsp_d.is_jump = fu_is_jump;
                    rsp_d.pc_jump = fu_pc_jump;
                    rsp_d.pc_wb   = fu_pc_wb;
                    first_d       = 1'b1;
                    state_d       = ST_RESOLVE;
                end else if (wdog_hit) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_RESOLVE: begin
                first_d = 1'b0;
                if (!req_q.wb || wb_ack)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            req_q   <= '0;
            rsp_q   <= '0;
            first_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            rsp_q   <= rsp_d;
            first_q <= first_d;
            err_q   <= err_d;
        end
    end

    assign issue_ready    = (state_q == ST_IDLE);
    assign fu_en          = (state_q == ST_ISSUE);
    assign fu_jalr        = req_q.jalr;
    assign fu_cmp_ctrl    = req_q.cmp_ctrl;
    assign fu_rs1         = req_q.rs1;
    assign fu_rs2         = req_q.rs2;
    assign fu_imm         = req_q.imm;
    assign fu_pc          = req_q.pc;
    assign redirect_valid = (state_q == ST_RESOLVE) && first_q && rsp_q.is_jump;
    assign redirect_pc    = rsp_q.pc_jump;
    assign wb_req         = (state_q == ST_RESOLVE) && req_q.wb;
    assign wb_rd          = req_q.rd;
    assign wb_data        = rsp_q.pc_wb;
    assign fetch_stall    = (state_q != ST_IDLE);
    assign timeout_err    = err_q;
endmodule
